// File: rtl/mem_seq_pkg.sv
// Shared types for the memory-stage op sequencer: op codes, FSM states,
// select encodings, the registered command bundle and per-op stack costs.
package mem_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDD  = 4'd1,
    OP_STD  = 4'd2,
    OP_PUSH = 4'd3,
    OP_POP  = 4'd4,
    OP_CALL = 4'd5,
    OP_RET  = 4'd6,
    OP_INT  = 4'd7,
    OP_RTI  = 4'd8
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD1,
    ST_PUSH_FL,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_POP_LO,
    ST_POP_HI,
    ST_POP_FL
  } mem_seq_state_t;

  localparam logic [1:0] ASEL_SP  = 2'b00;
  localparam logic [1:0] ASEL_LDD = 2'b01;
  localparam logic [1:0] ASEL_STD = 2'b10;

  localparam logic [1:0] WSRC_FLAGS = 2'b00;
  localparam logic [1:0] WSRC_PC_HI = 2'b01;
  localparam logic [1:0] WSRC_PC_LO = 2'b10;
  localparam logic [1:0] WSRC_REG   = 2'b11;

  typedef struct packed {
    logic       read;
    logic       write;
    logic       push;
    logic       pop;
    logic [1:0] asel;
    logic [1:0] wsrc;
    logic       flags_load;
    logic       op_done;
  } mem_cmd_t;

  function automatic logic [1:0] push_count(mem_op_t op);
    case (op)
      OP_PUSH: return 2'd1;
      OP_CALL: return 2'd2;
      OP_INT:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] pop_count(mem_op_t op);
    case (op)
      OP_POP:  return 2'd1;
      OP_RET:  return 2'd2;
      OP_RTI:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // ST_IDLE here means the op issues no memory command at all (NOP or unknown code).
  function automatic mem_seq_state_t first_state(mem_op_t op);
    case (op)
      OP_LDD, OP_STD, OP_PUSH, OP_POP: return ST_CMD1;
      OP_CALL:                         return ST_PUSH_HI;
      OP_INT:                          return ST_PUSH_FL;
      OP_RET, OP_RTI:                  return ST_POP_LO;
      default:                         return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_op_sequencer_if.sv
// Request handshake and memory-stage command bus of the op sequencer.
interface mem_op_sequencer_if #(
  parameter int OCC_W = 9
);
  logic                  req_valid;
  mem_seq_pkg::mem_op_t  req_op;
  logic                  req_ready;
  logic                  stall;
  logic                  memory_read;
  logic                  memory_write;
  logic                  memory_push;
  logic                  memory_pop;
  logic [1:0]            memory_address_select;
  logic [1:0]            memory_write_src_select;
  logic                  pc_load;
  logic                  flags_load;
  logic                  op_done;
  logic                  stack_fault;
  logic [OCC_W-1:0]      stack_occupancy;

  modport master (
    output req_valid, req_op,
    input  req_ready, stall, memory_read, memory_write, memory_push, memory_pop,
           memory_address_select, memory_write_src_select, pc_load, flags_load,
           op_done, stack_fault, stack_occupancy
  );

  modport slave (
    input  req_valid, req_op,
    output req_ready, stall, memory_read, memory_write, memory_push, memory_pop,
           memory_address_select, memory_write_src_select, pc_load, flags_load,
           op_done, stack_fault, stack_occupancy
  );
endinterface

// File: rtl/mem_seq_decode.sv
// Combinational decode of a sequencer state (plus latched op) into the
// memory command for that step; the top registers the result.
module mem_seq_decode
  import mem_seq_pkg::*;
(
  input  mem_seq_state_t state,
  input  mem_op_t        op,
  output mem_cmd_t       cmd
);

  always_comb begin
    // NOTE: assigning every output a default first keeps this block free of inferred latches.
    cmd = '0;
    case (state)
      ST_CMD1: begin
        cmd.op_done = 1'b1;
        case (op)
          OP_LDD: begin
            cmd.read = 1'b1;
            cmd.asel = ASEL_LDD;
          end
          OP_STD: begin
            cmd.write = 1'b1;
            cmd.asel  = ASEL_STD;
            cmd.wsrc  = WSRC_REG;
          end
          OP_PUSH: begin
            cmd.push  = 1'b1;
            cmd.write = 1'b1;
            cmd.wsrc  = WSRC_REG;
          end
          OP_POP: begin
            cmd.pop  = 1'b1;
            cmd.read = 1'b1;
          end
          default: cmd.op_done = 1'b0;
        endcase
      end
      ST_PUSH_FL: begin
        cmd.push  = 1'b1;
        cmd.write = 1'b1;
        cmd.wsrc  = WSRC_FLAGS;
      end
      ST_PUSH_HI: begin
        cmd.push  = 1'b1;
        cmd.write = 1'b1;
        cmd.wsrc  = WSRC_PC_HI;
      end
      ST_PUSH_LO: begin
        cmd.push    = 1'b1;
        cmd.write   = 1'b1;
        cmd.wsrc    = WSRC_PC_LO;
        cmd.op_done = 1'b1;
      end
      ST_POP_LO: begin
        cmd.pop  = 1'b1;
        cmd.read = 1'b1;
      end
      ST_POP_HI: begin
        cmd.pop     = 1'b1;
        cmd.read    = 1'b1;
        cmd.op_done = (op == OP_RET);
      end
      ST_POP_FL: begin
        cmd.pop        = 1'b1;
        cmd.read       = 1'b1;
        cmd.flags_load = 1'b1;
        cmd.op_done    = 1'b1;
      end
      default: cmd = '0;
    endcase
  end

endmodule

// File: rtl/mem_op_sequencer.sv
// Memory-stage controller: accepts one op per request, expands it into one
// registered memory command per cycle and mirrors stack occupancy.
module mem_op_sequencer
  import mem_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 511,
  parameter int OCC_W       = 9
) (
  input logic               clk,
  input logic               reset,
  mem_op_sequencer_if.slave bus
);

  localparam logic [OCC_W+1:0] DEPTH_EXT = (OCC_W+2)'(STACK_DEPTH);

  mem_seq_state_t   state_q, state_d;
  mem_op_t          op_q, op_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             fault_q, fault_d;
  logic             pc_load_q, pc_load_d;

  logic [OCC_W+1:0] occ_ext;
  logic             overflow, underflow;

  assign occ_ext   = {2'b00, occ_q};
  assign overflow  = (occ_ext + {{OCC_W{1'b0}}, push_count(bus.req_op)}) > DEPTH_EXT;
  assign underflow = occ_ext < {{OCC_W{1'b0}}, pop_count(bus.req_op)};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (overflow || underflow) begin
            fault_d = 1'b1;
          end else if (first_state(bus.req_op) != ST_IDLE) begin
            state_d = first_state(bus.req_op);
            op_d    = bus.req_op;
          end
        end
      end
      ST_PUSH_FL: state_d = ST_PUSH_HI;
      ST_PUSH_HI: state_d = ST_PUSH_LO;
      ST_POP_LO:  state_d = ST_POP_HI;
      ST_POP_HI:  state_d = (op_q == OP_RTI) ? ST_POP_FL : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Occupancy follows the command that was on the bus this cycle.
    occ_d = occ_q + {{(OCC_W-1){1'b0}}, cmd_q.push} - {{(OCC_W-1){1'b0}}, cmd_q.pop};

    // The 32-bit read shift register holds the full PC one cycle after POP_HI.
    pc_load_d = (state_q == ST_POP_HI);
  end

  // Decoding the next state lets the command leave a flop aligned with state_q.
  mem_seq_decode u_decode (
    .state (state_d),
    .op    (op_d),
    .cmd   (cmd_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      cmd_q     <= '0;
      occ_q     <= '0;
      fault_q   <= 1'b0;
      pc_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cmd_q     <= cmd_d;
      occ_q     <= occ_d;
      fault_q   <= fault_d;
      pc_load_q <= pc_load_d;
    end
  end

  assign bus.req_ready               = (state_q == ST_IDLE);
  assign bus.stall                   = (state_q != ST_IDLE);
  assign bus.memory_read             = cmd_q.read;
  assign bus.memory_write            = cmd_q.write;
  assign bus.memory_push             = cmd_q.push;
  assign bus.memory_pop              = cmd_q.pop;
  assign bus.memory_address_select   = cmd_q.asel;
  assign bus.memory_write_src_select = cmd_q.wsrc;
  assign bus.pc_load                 = pc_load_q;
  assign bus.flags_load              = cmd_q.flags_load;
  assign bus.op_done                 = cmd_q.op_done;
  assign bus.stack_fault             = fault_q;
  assign bus.stack_occupancy         = occ_q;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed bench for mem_op_sequencer: op sequences, stack faults at the
// boundaries, back-to-back single-step ops and reset mid-sequence.
module tb_mem_op_sequencer;
  import mem_seq_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_op_sequencer_if #(.OCC_W(9)) bus ();

  mem_op_sequencer #(
    .STACK_DEPTH (511),
    .OCC_W       (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ready, stall, rd, wr, push, pop, asel, wsrc, pc_load, flags_load, op_done, fault}
  function automatic logic [13:0] obs();
    return {bus.req_ready, bus.stall, bus.memory_read, bus.memory_write,
            bus.memory_push, bus.memory_pop, bus.memory_address_select,
            bus.memory_write_src_select, bus.pc_load, bus.flags_load,
            bus.op_done, bus.stack_fault};
  endfunction

  function automatic logic [13:0] cmd_v(logic rd, logic wr, logic pu, logic po,
                                        logic [1:0] asel, logic [1:0] wsrc,
                                        logic pcl, logic fll, logic done);
    return {1'b0, 1'b1, rd, wr, pu, po, asel, wsrc, pcl, fll, done, 1'b0};
  endfunction

  function automatic logic [13:0] idle_v(logic pcl, logic flt);
    return {1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, pcl, 1'b0, 1'b0, flt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input mem_op_t op);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    tick();
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;

    #2;
    check("reset_outputs", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    check("reset_occ", 32'(bus.stack_occupancy), 32'd0);
    #10 reset = 1'b1;
    tick();

    issue(OP_NOP);
    check("nop_idle", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));

    // CALL at occupancy 0.
    issue(OP_CALL);
    check("call_push_hi", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_PC_HI, 0, 0, 0)));
    tick();
    check("call_push_lo", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_PC_LO, 0, 0, 1)));
    tick();
    check("call_idle", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    check("call_occ", 32'(bus.stack_occupancy), 32'd2);

    // RET pops both PC words.
    issue(OP_RET);
    check("ret_pop_lo", 32'(obs()), 32'(cmd_v(1, 0, 0, 1, ASEL_SP, 2'b00, 0, 0, 0)));
    tick();
    check("ret_pop_hi", 32'(obs()), 32'(cmd_v(1, 0, 0, 1, ASEL_SP, 2'b00, 0, 0, 1)));
    tick();
    check("ret_pc_load", 32'(obs()), 32'(idle_v(1'b1, 1'b0)));
    check("ret_occ", 32'(bus.stack_occupancy), 32'd0);
    tick();
    check("ret_quiet", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));

    // INT then RTI.
    issue(OP_INT);
    check("int_push_fl", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_FLAGS, 0, 0, 0)));
    tick();
    check("int_push_hi", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_PC_HI, 0, 0, 0)));
    tick();
    check("int_push_lo", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_PC_LO, 0, 0, 1)));
    tick();
    check("int_idle", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    check("int_occ", 32'(bus.stack_occupancy), 32'd3);

    issue(OP_RTI);
    check("rti_pop_lo", 32'(obs()), 32'(cmd_v(1, 0, 0, 1, ASEL_SP, 2'b00, 0, 0, 0)));
    tick();
    check("rti_pop_hi", 32'(obs()), 32'(cmd_v(1, 0, 0, 1, ASEL_SP, 2'b00, 0, 0, 0)));
    tick();
    check("rti_pop_fl", 32'(obs()), 32'(cmd_v(1, 0, 0, 1, ASEL_SP, 2'b00, 1, 1, 1)));
    tick();
    check("rti_idle", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    check("rti_occ", 32'(bus.stack_occupancy), 32'd0);

    // POP on an empty stack is rejected.
    issue(OP_POP);
    check("pop_empty_fault", 32'(obs()), 32'(idle_v(1'b0, 1'b1)));
    check("pop_empty_occ", 32'(bus.stack_occupancy), 32'd0);
    tick();
    check("pop_empty_clear", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));

    // LDD, STD, PUSH back-to-back; requests during the stall are ignored.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LDD;
    tick();
    check("ldd_cmd", 32'(obs()), 32'(cmd_v(1, 0, 0, 0, ASEL_LDD, 2'b00, 0, 0, 1)));
    bus.req_op = OP_STD;
    tick();
    check("ldd_gap", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    tick();
    check("std_cmd", 32'(obs()), 32'(cmd_v(0, 1, 0, 0, ASEL_STD, WSRC_REG, 0, 0, 1)));
    bus.req_op = OP_PUSH;
    tick();
    check("std_gap", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    tick();
    check("push_cmd", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_REG, 0, 0, 1)));
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
    tick();
    check("push_idle", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    check("b2b_occ", 32'(bus.stack_occupancy), 32'd1);

    // Reset during INT step 2.
    issue(OP_INT);
    check("int2_push_fl", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_FLAGS, 0, 0, 0)));
    tick();
    check("int2_push_hi", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_PC_HI, 0, 0, 0)));
    #2 reset = 1'b0;
    #1;
    check("midreset_outputs", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    check("midreset_occ", 32'(bus.stack_occupancy), 32'd0);
    #3 reset = 1'b1;
    tick();
    check("postreset_idle", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));
    check("postreset_occ", 32'(bus.stack_occupancy), 32'd0);

    // Fill the stack to 510 words.
    for (int i = 0; i < 510; i++) begin
      issue(OP_PUSH);
      tick();
    end
    check("fill_occ", 32'(bus.stack_occupancy), 32'd510);

    issue(OP_CALL);
    check("call_full_fault", 32'(obs()), 32'(idle_v(1'b0, 1'b1)));
    check("call_full_occ", 32'(bus.stack_occupancy), 32'd510);
    tick();
    check("call_full_clear", 32'(obs()), 32'(idle_v(1'b0, 1'b0)));

    issue(OP_PUSH);
    check("push_last_cmd", 32'(obs()), 32'(cmd_v(0, 1, 1, 0, ASEL_SP, WSRC_REG, 0, 0, 1)));
    tick();
    check("push_last_occ", 32'(bus.stack_occupancy), 32'd511);

    issue(OP_PUSH);
    check("push_full_fault", 32'(obs()), 32'(idle_v(1'b0, 1'b1)));
    check("push_full_occ", 32'(bus.stack_occupancy), 32'd511);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
